iob_tdp_ram_arb: RTL
====================

// Module: iob_tdp_ram_arb
// PURPOSE
//  Round-robin arbiter sharing one true-dual-port RAM among N_REQ requesters.
//  Each cycle it grants up to two requests, one on RAM port A and one on port B, and drives the RAM's en/we/addr/data pins.
//  It steers q_a/q_b back to the requester that issued each read.
//  Sits between N_REQ masters and a 1-cycle-read-latency TDP RAM instance.
// PARAMETERS
//  N_REQ   4   number of requesters, 2..16
//  DATA_W  32  data width
//  ADDR_W  11  RAM address width
// PORTS
//  clk        in   1              clock; all logic on posedge
//  rst        in   1              synchronous reset, active-high
//  req_valid  in   N_REQ          request pending, one bit per requester
//  req_we     in   N_REQ          1=write, 0=read
//  req_addr   in   N_REQ*ADDR_W   addresses; requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   N_REQ*DATA_W   write data; requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  N_REQ          grant; request accepted this cycle (combinational)
//  rsp_valid  out  N_REQ          read data valid for requester i
//  rsp_rdata  out  N_REQ*DATA_W   read data; requester i at [i*DATA_W +: DATA_W]
//  en_a/we_a  out  1/1            RAM port A enable / write enable
//  addr_a     out  ADDR_W         RAM port A address
//  data_a     out  DATA_W         RAM port A write data
//  q_a        in   DATA_W         RAM port A read data
//  en_b, we_b, addr_b, data_b, q_b: same as port A, for port B
// BEHAVIOUR
//  - Reset: ptr=0, rsp_valid=0, rsp_rdata=0, all routing/pipeline registers cleared. Clear regardless of in-flight reads; their data is dropped.
//  - Handshake: a transfer occurs when req_valid[i]&&req_ready[i].
//    - req_ready depends on req_valid/we/addr and ptr only, never on rsp.
//    - A requester holds valid/we/addr/wdata stable until ready.
//  - Arbitration, combinational each cycle:
//    - Scan requesters ptr, ptr+1, ... mod N_REQ.
//    - First valid requester -> port A (gA). Next valid requester -> port B (gB).
//  - Collision rule: gB is dropped (req_ready=0, en_b=0) when addr_B==addr_A and (we_A|we_B). It retries next cycle.
//  - Pointer update:
//    - ptr <= (last granted index + 1) mod N_REQ, where last granted is gB if it was granted, else gA.
//    - No grant -> ptr holds.
//  - RAM drive:
//    - en_x=1 only for a granted port; we_x=req_we of its grantee.
//    - addr/data are muxed from the grantee.
//    - When en_x=0, addr/data/we are driven 0.
//  - Response: for a granted read on port x by requester i, at posedge+1 capture q_x into rsp_rdata[i] and pulse rsp_valid[i]=1 for one cycle.
//    - Read latency 1 cycle after the grant cycle.
//    - Writes produce no response.
//  - rsp_rdata[i] holds its last value when rsp_valid[i]=0.
//  - At most one read per requester per cycle, so A/B returns never target the same i.
//  - Back-to-back grants to the same requester on consecutive cycles are allowed (pipelined).
// CONFIGURATION
//  IOB_TDP_RAM_ARB_RSP_REG_EN
//    defined: an extra register stage on rsp_valid/rsp_rdata; read latency 2 cycles. Reset also clears this stage.
//    undefined: read latency 1 cycle, as above. Arbitration timing is identical in both cases.
// TESTING
//  1. Reset: hold rst=1 for 3 cycles with req_valid=4'hF -> req_ready=0 during reset. rsp_valid=0, en_a=en_b=0, ptr=0.
//  2. Fairness: all 4 requesters read continuously at distinct addresses.
//     -> grants are (0,1),(2,3),(0,1)...
//     -> each rsp_valid pulses every 2nd cycle, 1 cycle after its grant.
//  3. Collision: req0 writes 0x10=0xDEADBEEF, req1 reads 0x10, same cycle, ptr=0.
//     -> only req0 is granted.
//     -> next cycle req1 is granted on port A.
//     -> rsp_rdata[1]=0xDEADBEEF.
//  4. Wrap-around: ptr=3, req_valid=4'b1001.
//     -> port A=req3, port B=req0, next ptr=1.
//  5. Reset mid-read: grant a read to req2, assert rst the next cycle.
//     -> rsp_valid[2] stays 0 and rsp_rdata stays 0.
//  6. IOB_TDP_RAM_ARB_RSP_REG_EN defined: single read by req1 at 0x5 after a write of 0x1234.
//     -> rsp_valid[1]=1 exactly 2 cycles after the grant, rsp_rdata[1]=0x1234.

Source files
------------

// File: rtl/iob_tdp_ram_arb.sv
// Round-robin arbiter granting up to two of N_REQ requesters per cycle onto the A/B ports of one TDP RAM.
// Read data returns one clock after the RAM sample edge (two with IOB_TDP_RAM_ARB_RSP_REG_EN defined).
// Backpressure: req_ready is combinational from req_valid/we/addr and ptr; losers and collided B-grants retry.
module iob_tdp_ram_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [N_REQ*DATA_W-1:0]   rsp_rdata,
    output logic                      en_a,
    output logic                      we_a,
    output logic [ADDR_W-1:0]         addr_a,
    output logic [DATA_W-1:0]         data_a,
    input  logic [DATA_W-1:0]         q_a,
    output logic                      en_b,
    output logic                      we_b,
    output logic [ADDR_W-1:0]         addr_b,
    output logic [DATA_W-1:0]         data_b,
    input  logic [DATA_W-1:0]         q_b
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]     ptr;
    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];
    logic [N_REQ-1:0]  act;
    logic              ga_vld, gb_vld, gb_ok;
    logic [IW-1:0]     ga, gb, last_g;
    logic [IW:0]       scan, ptr_inc;
    logic [IW-1:0]     ptr_nxt;

    logic              rd_a_vld, rd_b_vld;
    logic [IW-1:0]     rd_a_idx, rd_b_idx;
    logic [N_REQ-1:0]        cap_valid;
    logic [N_REQ*DATA_W-1:0] cap_rdata;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    // Nothing is granted while reset is asserted.
    assign act = req_valid & {N_REQ{~rst}};

    // Scan from ptr: first active requester takes port A, the next one port B.
    always_comb begin
        ga_vld = 1'b0;
        gb_vld = 1'b0;
        ga     = '0;
        gb     = '0;
        scan   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(N_REQ)) scan = scan - (IW+1)'(N_REQ);
            if (act[scan[IW-1:0]]) begin
                if (!ga_vld) begin
                    ga_vld = 1'b1;
                    ga     = scan[IW-1:0];
                end else if (!gb_vld) begin
                    gb_vld = 1'b1;
                    gb     = scan[IW-1:0];
                end
            end
        end
    end

    // Port B yields when it hits port A's address and either side writes.
    assign gb_ok = gb_vld &&
                   !((addr_arr[gb] == addr_arr[ga]) && (req_we[ga] || req_we[gb]));

    // Grants back to requesters and RAM pin drive; idle ports drive zeros.
    always_comb begin
        req_ready = '0;
        if (ga_vld) req_ready[ga] = 1'b1;
        if (gb_ok)  req_ready[gb] = 1'b1;
        en_a   = ga_vld;
        we_a   = ga_vld & req_we[ga];
        addr_a = ga_vld ? addr_arr[ga]  : '0;
        data_a = ga_vld ? wdata_arr[ga] : '0;
        en_b   = gb_ok;
        we_b   = gb_ok & req_we[gb];
        addr_b = gb_ok ? addr_arr[gb]  : '0;
        data_b = gb_ok ? wdata_arr[gb] : '0;
    end

    // Next pointer is one past the last granted requester, wrapping at N_REQ.
    always_comb begin
        last_g  = gb_ok ? gb : ga;
        ptr_inc = {1'b0, last_g} + 1'b1;
        ptr_nxt = (ptr_inc == (IW+1)'(N_REQ)) ? '0 : ptr_inc[IW-1:0];
    end

    // Round-robin pointer; holds when nothing was granted.
    always_ff @(posedge clk) begin
        if (rst)         ptr <= '0;
        else if (ga_vld) ptr <= ptr_nxt;
    end

    // Remember which requester owns the read currently inside the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a_vld <= 1'b0;
            rd_b_vld <= 1'b0;
            rd_a_idx <= '0;
            rd_b_idx <= '0;
        end else begin
            rd_a_vld <= en_a & ~we_a;
            rd_b_vld <= en_b & ~we_b;
            rd_a_idx <= ga;
            rd_b_idx <= gb;
        end
    end

    // Capture RAM read data into the owning requester's lane; other lanes hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= '0;
            cap_rdata <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cap_valid[i] <= 1'b0;
                if (rd_a_vld && rd_a_idx == IW'(i)) begin
                    cap_valid[i]                  <= 1'b1;
                    cap_rdata[i*DATA_W +: DATA_W] <= q_a;
                end else if (rd_b_vld && rd_b_idx == IW'(i)) begin
                    cap_valid[i]                  <= 1'b1;
                    cap_rdata[i*DATA_W +: DATA_W] <= q_b;
                end
            end
        end
    end

`ifdef IOB_TDP_RAM_ARB_RSP_REG_EN
    // Extra retiming stage on the response path.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= cap_valid;
            rsp_rdata <= cap_rdata;
        end
    end
`else
    assign rsp_valid = cap_valid;
    assign rsp_rdata = cap_rdata;
`endif

endmodule
